// File: rtl/dot_product_pkg.sv
// Shared constants and types for the dot-product datapath: lane geometry,
// packer state encoding and the accumulator result width.
package dot_product_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_DW = 8;

  // Result width used by the downstream dot_product stage.
  localparam int RES_W = 2 * DEF_DW + $bits(DEF_N);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } pack_state_t;

endpackage

// File: rtl/operand_packer.sv
// Collects element pairs into two N-lane vectors and hands the packed pair to
// the dot_product stage through a valid/ready handshake.
module operand_packer
  import dot_product_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_a,
  input  logic [DW-1:0]         in_b,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*DW-1:0]       out_vec1,
  output logic [N*DW-1:0]       out_vec2,
  output logic [$clog2(N+1)-1:0] out_count
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);

  pack_state_t   state;
  logic [IW-1:0] idx;
  logic          accept;
  logic          transfer;
  logic          vec_done;

  // Writing lane 0 starts a fresh vector, so unused upper lanes read as zero.
  function automatic logic [N*DW-1:0] load_lane(input logic [N*DW-1:0] cur,
                                                 input logic [IW-1:0]   lane,
                                                 input logic [DW-1:0]   d);
    logic [N*DW-1:0] nxt;
    nxt = (lane == '0) ? '0 : cur;
    nxt[lane*DW +: DW] = d;
    return nxt;
  endfunction

  assign out_valid = (state == FULL);
  assign in_ready  = (state == FILL) ? 1'b1 : out_ready;
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;
  assign vec_done  = in_last || (idx == IW'(N-1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FILL;
      idx       <= '0;
      out_vec1  <= '0;
      out_vec2  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            out_vec1 <= load_lane(out_vec1, idx, in_a);
            out_vec2 <= load_lane(out_vec2, idx, in_b);
            if (vec_done) begin
              state     <= FULL;
              out_count <= CW'(idx) + CW'(1);
              idx       <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        FULL: begin
          if (transfer) begin
            // An element arriving alongside the transfer opens the next vector.
            if (accept) begin
              out_vec1 <= load_lane(out_vec1, '0, in_a);
              out_vec2 <= load_lane(out_vec2, '0, in_b);
              if (in_last) begin
                state     <= FULL;
                out_count <= CW'(1);
                idx       <= '0;
              end else begin
                state <= FILL;
                idx   <= IW'(1);
              end
            end else begin
              state <= FILL;
              idx   <= '0;
            end
          end
        end
        default: begin
          state <= FILL;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_packer.sv
// Scoreboard bench for operand_packer: a reference model predicts handshakes
// and packed vectors, including the dot product the vectors would produce.
module tb_operand_packer;
  import dot_product_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    logic [N*DW-1:0] v1;
    logic [N*DW-1:0] v2;
    logic [2:0]      cnt;
    logic [RES_W-1:0] dot;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] out_vec1;
  logic [N*DW-1:0] out_vec2;
  logic [2:0]      out_count;

  int testsRun = 0;
  int testsFailed = 0;
  int accCount = 0;
  int xferCount = 0;
  int pushed = 0;

  exp_t            sbQueue[$];
  logic            mFull = 1'b0;
  int              mIdx = 0;
  logic [N*DW-1:0] cur1 = '0;
  logic [N*DW-1:0] cur2 = '0;
  logic [RES_W-1:0] curDot = '0;

  operand_packer #(.N(N), .DW(DW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec1  (out_vec1),
    .out_vec2  (out_vec2),
    .out_count (out_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic last, input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_last   = last;
    out_ready = ordy;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [RES_W-1:0] dotOf(input logic [N*DW-1:0] v1, input logic [N*DW-1:0] v2);
    logic [RES_W-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++)
      s += RES_W'(v1[k*DW +: DW]) * RES_W'(v2[k*DW +: DW]);
    return s;
  endfunction

  // Reference model, sampled on the falling edge while inputs are stable.
  always @(negedge clock) begin
    logic expReady, acc, xf;
    if (!reset_n) begin
      sbQueue.delete();
      mFull  = 1'b0;
      mIdx   = 0;
      cur1   = '0;
      cur2   = '0;
      curDot = '0;
    end else begin
      expReady = mFull ? out_ready : 1'b1;
      checkOutput("in_ready", in_ready, expReady);
      checkOutput("out_valid", out_valid, mFull);
      if (mFull) begin
        if (sbQueue.size() == 0) begin
          checkOutput("sb_underflow", 0, 1);
        end else begin
          checkOutput("out_vec1", out_vec1, sbQueue[0].v1);
          checkOutput("out_vec2", out_vec2, sbQueue[0].v2);
          checkOutput("out_count", out_count, sbQueue[0].cnt);
          checkOutput("dot", dotOf(out_vec1, out_vec2), sbQueue[0].dot);
        end
      end
      if (in_valid && in_ready) accCount++;
      if (out_valid && out_ready) xferCount++;
      acc = in_valid && expReady;
      xf  = mFull && out_ready;
      if (xf) begin
        if (sbQueue.size() > 0) void'(sbQueue.pop_front());
        mFull = 1'b0;
      end
      if (acc) begin
        if (mIdx == 0) begin
          cur1   = '0;
          cur2   = '0;
          curDot = '0;
        end
        cur1[mIdx*DW +: DW] = in_a;
        cur2[mIdx*DW +: DW] = in_b;
        curDot += RES_W'(in_a) * RES_W'(in_b);
        if (in_last || mIdx == N-1) begin
          sbQueue.push_back('{cur1, cur2, 3'(mIdx + 1), curDot});
          pushed++;
          mFull = 1'b1;
          mIdx  = 0;
        end else begin
          mIdx++;
        end
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_ready"}, in_ready, 1);
    checkOutput({tag, "_vec1"}, out_vec1, 0);
    checkOutput({tag, "_vec2"}, out_vec2, 0);
    checkOutput({tag, "_count"}, out_count, 0);
  endtask

  initial begin
    int cycles;
    int target;
    reset_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    #2;
    checkResetState("rst");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    // Full-length vector, then held for five cycles with extra input offered.
    for (int k = 0; k < 4; k++)
      applyStimulus(1, DW'(k+1), DW'(k+5), k == 3, 0);
    checkOutput("t1_valid", out_valid, 1);
    checkOutput("t1_vec1", out_vec1, 32'h04030201);
    checkOutput("t1_vec2", out_vec2, 32'h08070605);
    checkOutput("t1_count", out_count, 4);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 8'hEE, 8'hDD, 1, 0);
      checkOutput("hold_vec1", out_vec1, 32'h04030201);
      checkOutput("hold_ready", in_ready, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);

    // Early last leaves upper lanes zero.
    applyStimulus(1, 9, 1, 0, 0);
    applyStimulus(1, 10, 1, 1, 0);
    checkOutput("t2_vec1", out_vec1, 32'h00000A09);
    checkOutput("t2_vec2", out_vec2, 32'h00000101);
    checkOutput("t2_count", out_count, 2);
    applyStimulus(0, 0, 0, 0, 1);

    // Three back-to-back vectors with no bubble.
    accCount = 0;
    xferCount = 0;
    for (int k = 0; k < 12; k++)
      applyStimulus(1, DW'(k*3+1), DW'(k+2), (k % 4) == 3, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("b2b_accepts", accCount, 12);
    checkOutput("b2b_xfers", xferCount, 3);

    // Reset mid-vector discards the partial contents.
    applyStimulus(1, 8'h11, 8'h22, 0, 0);
    applyStimulus(1, 8'h33, 8'h44, 0, 0);
    reset_n = 1'b0;
    #1;
    checkResetState("midrst");
    applyStimulus(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++)
      applyStimulus(1, 8'hAA, 8'hAA, k == 3, 0);
    checkOutput("t5_vec1", out_vec1, 32'hAAAAAAAA);
    checkOutput("t5_vec2", out_vec2, 32'hAAAAAAAA);
    checkOutput("t5_count", out_count, 4);
    applyStimulus(0, 0, 0, 0, 1);

    // Random traffic: random last, valid and backpressure.
    target = pushed + 1000;
    cycles = 0;
    while (pushed < target && cycles < 20000) begin
      applyStimulus(($urandom_range(0, 3) != 0), DW'($urandom), DW'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
      cycles++;
    end
    if (cycles >= 20000) checkOutput("rand_timeout", 0, 1);
    cycles = 0;
    while (sbQueue.size() > 0 && cycles < 20) begin
      applyStimulus(0, 0, 0, 0, 1);
      cycles++;
    end
    checkOutput("drain_empty", sbQueue.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
